alu_seq_md: RTL and testbench
=============================

// Module: alu_seq_md
// PURPOSE
//  Sequential, XLEN-parametrised successor to the single-cycle ALU. Executes every base
//  AluOp and the RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) behind a valid/ready
//  handshake; multiply and divide run iteratively, one bit per cycle. Sits in the core's
//  execute stage and stalls the core via in_ready/out_valid while an M op is in flight.
// PARAMETERS
//  XLEN   32  operand/result width (>=8, even)
//  OP_W   5   op code width; op[4]=0 base ALU, op[4]=1 M-extension
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      asynchronous reset, active low
//  in_valid      in   1      operands/op presented
//  in_ready      out  1      block accepts a new op this cycle
//  op            in   OP_W   base: op[3:0] = shared AluOp code; M: op[2:0] = RV funct3
//  src_a, src_b  in   XLEN   operands
//  kill          in   1      abort in-flight op (pipeline flush)
//  out_valid     out  1      result/flags valid, held until out_ready
//  out_ready     in   1      consumer takes result
//  result        out  XLEN   registered result
//  zero_flag, negative_flag, carry_flag, overflow_flag  out 1 each  registered flags
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=0, all flags=0.
//  - FSM: IDLE -> (accept, base op) -> DONE; IDLE -> (accept, M op) -> BUSY;
//    BUSY -> (count==XLEN-1) -> DONE; DONE -> (out_ready) -> IDLE; any state -> (kill) -> IDLE.
//  - Accept = in_valid && in_ready; in_ready=1 only in IDLE. No overlap of ops.
//  - Latency: base op out_valid 1 cycle after accept; M op out_valid XLEN+1 cycles after accept.
//  - Base ops identical to the single-cycle ALU at width XLEN: ADD carry = carry-out, SUB carry
//    = NOT borrow, signed overflow per operand/result signs; shifts use src_b[$clog2(XLEN)-1:0];
//    SLT/SLTU return 1/0; undefined codes give result 0 with flags from 0.
//  - MUL: low XLEN of product; MULH/MULHSU/MULHU: high XLEN of signed*signed / signed*unsigned /
//    unsigned*unsigned 2XLEN-bit product. Shift-add on magnitudes, sign fixed at end.
//  - DIV/REM signed truncating toward zero, rem takes dividend sign; restoring, 1 bit/cycle.
//  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> src_a. Still takes full XLEN cycles.
//  - Signed overflow (MIN / -1): DIV -> MIN, REM -> 0.
//  - M ops: zero/negative from result, carry=overflow=0.
//  - out_valid && !out_ready: result/flags held stable, in_ready stays 0.
//  - kill wins over completion in the same cycle: out_valid=0 next cycle, no result issued;
//    kill in IDLE is ignored; kill with in_valid in IDLE blocks acceptance that cycle.
//  - Operands are latched at accept; src_a/src_b changes during BUSY have no effect.
//  - rst_n asserted mid-op: immediate return to reset values, no partial result visible.
// STRUCTURE
//  - Shared defines header: AluOp codes (existing), M funct3 codes, OP_W, FSM state encodings.
//  - Sub-module alu_muldiv_iter: iterative mul/div datapath (start, busy, done, kill, XLEN param);
//    top holds FSM, handshake, base combinational ALU and output registers.
// TESTING
//  - ADD 0xFFFFFFFF+1 -> result 0, Z=1, C=1, V=0, out_valid 1 cycle after accept.
//  - SUB 0x80000000-1 -> 0x7FFFFFFF, V=1, C=1; SRA 0x80000000 by 4 -> 0xF8000000.
//  - MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU same -> 0xFFFFFFFE; MUL 7*-3 -> 0xFFFFFFEB; 33 cycles.
//  - DIV 7/0 -> 0xFFFFFFFF, REM 7/0 -> 7; DIV 0x80000000/-1 -> 0x80000000, REM -> 0; DIV -7/2 -> -3, REM -> -1.
//  - out_ready held low 5 cycles after completion -> result stable, in_ready=0; then pops, IDLE.
//  - kill at BUSY cycle 10 -> no out_valid, in_ready=1 next cycle; rst_n low mid-DIV -> reset values.

Source files
------------

// File: rtl/alu_seq_md_pkg.sv
// Shared definitions for the sequential ALU: base op codes, M-extension funct3 codes,
// default op width and FSM state encodings.
package alu_seq_md_pkg;

    localparam int OP_W_DEFAULT = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Which operands an M op treats as two's-complement.
    function automatic logic md_a_signed(input logic [2:0] f);
        return (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
    endfunction

    function automatic logic md_b_signed(input logic [2:0] f);
        return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
    endfunction

endpackage

// File: rtl/alu_seq_md_muldiv.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with the sign applied to the final result.
module alu_muldiv_iter
    import alu_seq_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(XLEN);

    logic [2:0]        op_q;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   opd_q;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     sum, rsh, diff;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;
    logic              last;

    always_comb begin
        a_neg = md_a_signed(op_i) && a_i[XLEN-1];
        b_neg = md_b_signed(op_i) && b_i[XLEN-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;
    end

    // acc/lo hold the product high/low halves for multiply, remainder/quotient for divide.
    always_comb begin
        sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        rsh  = {acc_q, lo_q[XLEN-1]};
        diff = rsh - {1'b0, opd_q};
        if (op_q[2]) begin
            if (rsh >= {1'b0, opd_q}) begin
                acc_d = diff[XLEN-1:0];
                lo_d  = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = rsh[XLEN-1:0];
                lo_d  = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_d = sum[XLEN:1];
            lo_d  = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    // The result is taken straight from the final iteration so it is ready on the done cycle.
    always_comb begin
        last   = busy_q && (cnt_q == CNT_W'(XLEN-1));
        prod   = {acc_d, lo_d};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -lo_d : lo_d;
        rem_s  = neg_q ? -acc_d : acc_d;
        if (op_q[2]) begin
            result_o = op_q[1] ? rem_s : quo_s;
        end else if (op_q == MD_MUL) begin
            result_o = prod_s[XLEN-1:0];
        end else begin
            result_o = prod_s[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            acc_q  <= '0;
            lo_q   <= '0;
            opd_q  <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (kill_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            op_q   <= op_i;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (op_i[2]) begin
                lo_q  <= a_mag;
                opd_q <= b_mag;
                // Divide by zero keeps the all-ones quotient unsigned; remainder follows the dividend.
                neg_q <= op_i[1] ? a_neg : ((a_neg ^ b_neg) && (b_i != '0));
            end else begin
                lo_q  <= b_mag;
                opd_q <= a_mag;
                neg_q <= a_neg ^ b_neg;
            end
        end else if (busy_q) begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            if (last) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = last;

endmodule

// File: rtl/alu_seq_md.sv
// Sequential ALU with RV32M support behind a valid/ready handshake: base ops complete in one
// cycle, M ops run on the iterative mul/div datapath.
module alu_seq_md
    import alu_seq_md_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = OP_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero_flag,
    output logic            negative_flag,
    output logic            carry_flag,
    output logic            overflow_flag
);

    localparam int SHW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d, neg_q, neg_d, carry_q, carry_d, ovf_q, ovf_d;
    logic            start_md, load_base, load_md;
    logic            md_busy, md_done;
    logic [XLEN-1:0] md_res;

    logic [XLEN-1:0] alu_res;
    logic            alu_c, alu_v;
    logic [XLEN:0]   add_full, sub_full;
    logic [SHW-1:0]  shamt;

    alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_md),
        .kill_i   (kill),
        .op_i     (op[2:0]),
        .a_i      (src_a),
        .b_i      (src_b),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_res)
    );

    always_comb begin
        add_full = {1'b0, src_a} + {1'b0, src_b};
        sub_full = {1'b0, src_a} - {1'b0, src_b};
        shamt    = src_b[SHW-1:0];
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op[3:0])
            ALU_ADD: begin
                alu_res = add_full[XLEN-1:0];
                alu_c   = add_full[XLEN];
                alu_v   = (src_a[XLEN-1] == src_b[XLEN-1]) && (alu_res[XLEN-1] != src_a[XLEN-1]);
            end
            ALU_SUB: begin
                alu_res = sub_full[XLEN-1:0];
                alu_c   = ~sub_full[XLEN];
                alu_v   = (src_a[XLEN-1] != src_b[XLEN-1]) && (alu_res[XLEN-1] != src_a[XLEN-1]);
            end
            ALU_AND:  alu_res = src_a & src_b;
            ALU_OR:   alu_res = src_a | src_b;
            ALU_XOR:  alu_res = src_a ^ src_b;
            ALU_SLL:  alu_res = src_a << shamt;
            ALU_SRL:  alu_res = src_a >> shamt;
            ALU_SRA:  alu_res = $signed(src_a) >>> shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            default:  ;
        endcase
    end

    // A kill in any state drops straight to IDLE and also blocks acceptance in IDLE.
    always_comb begin
        state_d   = state_q;
        start_md  = 1'b0;
        load_base = 1'b0;
        load_md   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready && !kill) begin
                    if (op[OP_W-1]) begin
                        state_d  = ST_BUSY;
                        start_md = 1'b1;
                    end else begin
                        state_d   = ST_DONE;
                        load_base = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else if (md_done) begin
                    state_d = ST_DONE;
                    load_md = 1'b1;
                end
            end
            ST_DONE: begin
                if (kill || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        if (load_base) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            neg_d    = alu_res[XLEN-1];
            carry_d  = alu_c;
            ovf_d    = alu_v;
        end else if (load_md) begin
            result_d = md_res;
            zero_d   = (md_res == '0);
            neg_d    = md_res[XLEN-1];
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE) && !md_busy;
    assign out_valid     = (state_q == ST_DONE);
    assign result        = result_q;
    assign zero_flag     = zero_q;
    assign negative_flag = neg_q;
    assign carry_flag    = carry_q;
    assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_alu_seq_md.sv
// Directed self-checking bench for alu_seq_md: base ops, M ops, backpressure, kill and
// mid-operation reset, with hand-computed expected values.
module tb_alu_seq_md;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        kill = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        in_ready, out_valid;
    logic        zero_flag, negative_flag, carry_flag, overflow_flag;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    always #5 clk = ~clk;

    alu_seq_md #(.XLEN(32), .OP_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .op            (op),
        .src_a         (src_a),
        .src_b         (src_b),
        .kill          (kill),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero_flag     (zero_flag),
        .negative_flag (negative_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag)
    );

    // Issue one op, scramble operands after accept, wait (bounded) for out_valid, then pop it.
    task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [3:0] fl, output int cyc);
        op = o; src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; src_a = ~a; src_b = b ^ 32'h5A5A_5A5A;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        res = result;
        fl  = {zero_flag, negative_flag, carry_flag, overflow_flag};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        in_valid = 1'b1; op = 5'h00; src_a = 32'd5; src_b = 32'd5;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL reset_handshake: got in_ready/out_valid=%b expected 10", {in_ready, out_valid});
        end
        checks++;
        if (result !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_result: got %h expected 00000000", result);
        end
        checks++;
        if ({zero_flag, negative_flag, carry_flag, overflow_flag} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 0000",
                     {zero_flag, negative_flag, carry_flag, overflow_flag});
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_base_ops();
        vec_t v [13] = '{
            '{5'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010},
            '{5'h01, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011},
            '{5'h07, 32'h80000000, 32'h00000024, 32'hF8000000, 4'b0100},
            '{5'h08, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000},
            '{5'h09, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000},
            '{5'h05, 32'h00000001, 32'h0000001F, 32'h80000000, 4'b0100},
            '{5'h06, 32'h80000000, 32'h00000004, 32'h08000000, 4'b0000},
            '{5'h04, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000},
            '{5'h0F, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1000},
            '{5'h01, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b0100},
            '{5'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101},
            '{5'h02, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 4'b0000},
            '{5'h03, 32'h000000F0, 32'h00000F00, 32'h00000FF0, 4'b0000}
        };
        logic [31:0] res;
        logic [3:0]  fl;
        int          cyc;
        for (int i = 0; i < 13; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, res, fl, cyc);
            checks++;
            if (res !== v[i].res) begin
                failures++;
                $display("[TB] FAIL base[%0d]_result: got %h expected %h", i, res, v[i].res);
            end
            checks++;
            if (fl !== v[i].fl) begin
                failures++;
                $display("[TB] FAIL base[%0d]_flags: got %b expected %b", i, fl, v[i].fl);
            end
            checks++;
            if (cyc !== 1) begin
                failures++;
                $display("[TB] FAIL base[%0d]_latency: got %0d expected 1", i, cyc);
            end
        end
    endtask

    task automatic test_muldiv();
        vec_t v [15] = '{
            '{5'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000},
            '{5'h13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100},
            '{5'h10, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 4'b0100},
            '{5'h12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0100},
            '{5'h11, 32'h80000000, 32'h80000000, 32'h40000000, 4'b0000},
            '{5'h14, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 4'b0100},
            '{5'h16, 32'h00000007, 32'h00000000, 32'h00000007, 4'b0000},
            '{5'h14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0100},
            '{5'h16, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b1000},
            '{5'h14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 4'b0100},
            '{5'h16, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 4'b0100},
            '{5'h15, 32'h00000064, 32'h00000007, 32'h0000000E, 4'b0000},
            '{5'h17, 32'h00000064, 32'h00000007, 32'h00000002, 4'b0000},
            '{5'h14, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 4'b0100},
            '{5'h16, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 4'b0100}
        };
        logic [31:0] res;
        logic [3:0]  fl;
        int          cyc;
        for (int i = 0; i < 15; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, res, fl, cyc);
            checks++;
            if (res !== v[i].res) begin
                failures++;
                $display("[TB] FAIL md[%0d]_result: got %h expected %h", i, res, v[i].res);
            end
            checks++;
            if (fl !== v[i].fl) begin
                failures++;
                $display("[TB] FAIL md[%0d]_flags: got %b expected %b", i, fl, v[i].fl);
            end
            checks++;
            if (cyc !== 33) begin
                failures++;
                $display("[TB] FAIL md[%0d]_latency: got %0d expected 33", i, cyc);
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        op = 5'h15; src_a = 32'd100; src_b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (!out_valid) begin
            failures++;
            $display("[TB] FAIL bp_complete: got out_valid=0 expected 1 within 100 cycles");
        end
        // A competing request during the hold must not be taken.
        in_valid = 1'b1; op = 5'h00; src_a = 32'd1; src_b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'h0000000E}) begin
                failures++;
                $display("[TB] FAIL bp_hold[%0d]: got valid=%b ready=%b result=%h expected valid=1 ready=0 result=0000000e",
                         i, out_valid, in_ready, result);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL bp_pop: got valid/ready=%b expected 01", {out_valid, in_ready});
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_no_accept: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_kill();
        int seen = 0;
        op = 5'h10; src_a = 32'd3; src_b = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL kill_busy: got valid/ready=%b expected 01", {out_valid, in_ready});
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("[TB] FAIL kill_no_result: got %0d valid cycles expected 0", seen);
        end

        op = 5'h00; src_a = 32'd2; src_b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL kill_done_setup: got out_valid=%b expected 1", out_valid);
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL kill_done: got valid/ready=%b expected 01", {out_valid, in_ready});
        end

        in_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL kill_idle_block: got valid/ready=%b expected 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic [3:0]  fl;
        int          cyc;
        run_op(5'h10, 32'd6, 32'd7, res, fl, cyc);
        checks++;
        if (res !== 32'd42) begin
            failures++;
            $display("[TB] FAIL b2b_mul: got %h expected 0000002a", res);
        end
        run_op(5'h01, 32'd10, 32'd3, res, fl, cyc);
        checks++;
        if ({res, fl} !== {32'd7, 4'b0010}) begin
            failures++;
            $display("[TB] FAIL b2b_sub: got %h/%b expected 00000007/0010", res, fl);
        end
        run_op(5'h14, 32'd100, 32'hFFFFFFF9, res, fl, cyc);
        checks++;
        if ({res, fl} !== {32'hFFFFFFF2, 4'b0100}) begin
            failures++;
            $display("[TB] FAIL b2b_div: got %h/%b expected fffffff2/0100", res, fl);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res;
        logic [3:0]  fl;
        int          cyc;
        int          seen = 0;
        op = 5'h14; src_a = 32'd1000; src_b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({in_ready, out_valid, result} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("[TB] FAIL rst_mid_state: got ready=%b valid=%b result=%h expected 1/0/00000000",
                     in_ready, out_valid, result);
        end
        checks++;
        if ({zero_flag, negative_flag, carry_flag, overflow_flag} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL rst_mid_flags: got %b expected 0000",
                     {zero_flag, negative_flag, carry_flag, overflow_flag});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("[TB] FAIL rst_mid_no_result: got %0d valid cycles expected 0", seen);
        end
        run_op(5'h00, 32'd1, 32'd1, res, fl, cyc);
        checks++;
        if ({res, cyc} !== {32'd2, 32'd1}) begin
            failures++;
            $display("[TB] FAIL rst_mid_recover: got %h in %0d cycles expected 00000002 in 1", res, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_base_ops();
        test_muldiv();
        test_backpressure();
        test_kill();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
